obi_wb_bridge_mt: RTL

Single-clock OBI-slave to Wishbone-classic-master bridge. It accepts up to DEPTH pipelined OBI requests into a command FIFO and replays them one at a time as Wishbone transfers. Each response returns in order on OBI rvalid/rdata, with an error flag. It sits between the core's OBI data port and the peripheral Wishbone interconnect. Additions over the previous bridge: a configurable address window, a bus-error path, and a transfer timeout.

---
 rtl/obi_wb_bridge_mt_pkg.sv | 24 ++
 rtl/obi_wb_bridge_mt_if.sv | 43 ++++
 rtl/obi_wb_cmd_fifo.sv | 58 +++++
 rtl/obi_wb_bridge_mt.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/obi_wb_bridge_mt_pkg.sv
// Shared types for the OBI-to-Wishbone bridge: FSM states, response kinds, default widths.
// No logic lives here.
package obi_wb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        WB_IDLE,
        WB_BUSY
    } wb_state_e;

    typedef enum logic [1:0] {
        RSP_OK,
        RSP_BUS_ERR,
        RSP_TIMEOUT
    } rsp_kind_e;

    // A zero timeout still needs a one-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/obi_wb_bridge_mt_if.sv
// OBI slave + Wishbone master signal bundle; 'slave' is the bridge view, 'master' the surroundings.
// Pure wiring, no latency or flow control of its own.
interface obi_wb_bridge_mt_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              obi_req_i;
    logic              obi_gnt_o;
    logic [ADDR_W-1:0] obi_addr_i;
    logic              obi_wr_en_i;
    logic [BE_W-1:0]   obi_byte_en_i;
    logic [DATA_W-1:0] obi_wdata_i;
    logic              obi_rvalid_o;
    logic [DATA_W-1:0] obi_rdata_o;
    logic              obi_err_o;

    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_wdata_o;
    logic              wb_wr_en_o;
    logic [BE_W-1:0]   wb_byte_en_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic [DATA_W-1:0] wb_rdata_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport slave (
        input  obi_req_i, obi_addr_i, obi_wr_en_i, obi_byte_en_i, obi_wdata_i,
        input  wb_rdata_i, wb_ack_i, wb_err_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        output wb_addr_o, wb_wdata_o, wb_wr_en_o, wb_byte_en_o, wb_stb_o, wb_cyc_o
    );

    modport master (
        output obi_req_i, obi_addr_i, obi_wr_en_i, obi_byte_en_i, obi_wdata_i,
        output wb_rdata_i, wb_ack_i, wb_err_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        input  wb_addr_o, wb_wdata_o, wb_wr_en_o, wb_byte_en_o, wb_stb_o, wb_cyc_o
    );

endinterface

// File: rtl/obi_wb_cmd_fifo.sv
// Generic synchronous FIFO, registered storage with combinational head read.
// Push ignored when full, pop ignored when empty; full/empty depend on registered pointers only.
module obi_wb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_wr_en;
    logic             w_rd_en;

    generate
        if (DEPTH == 1) begin : g_single
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
        end else begin : g_multi
            assign w_wr_idx = r_wr_ptr[AW-1:0];
            assign w_rd_idx = r_rd_ptr[AW-1:0];
        end
    endgenerate

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = ((r_wr_ptr - r_rd_ptr) == PW'(DEPTH));
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_dout  = r_mem[w_rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[w_wr_idx] <= i_din;
    end

endmodule

// File: rtl/obi_wb_bridge_mt.sv
// OBI slave to Wishbone classic master: queues DEPTH requests, one WB transfer at a time, in-order responses.
// req->rvalid is 3 cycles minimum; gnt = !fifo_full from registered state; timeout/err give error responses.
module obi_wb_bridge_mt
    import obi_wb_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                DEPTH        = 2,
    parameter logic [ADDR_W-1:0] WB_ADDR_MASK = ADDR_W'(32'h000F_FFFF),
    parameter int                TIMEOUT      = 255
) (
    input logic               clk_i,
    input logic               rst_i,
    obi_wb_bridge_mt_if.slave bus
);
    localparam int                BE_W     = DATA_W / 8;
    localparam int                CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    cmd_t              w_push_cmd;
    cmd_t              w_pop_cmd;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_term;
    logic              w_timeout;
    rsp_kind_e         w_rsp;
    wb_state_e         r_state;
    wb_state_e         w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_wdata;
    logic              r_wb_we;
    logic [BE_W-1:0]   r_wb_be;
    logic              r_cyc;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    assign bus.obi_gnt_o = !w_full;
    assign w_push        = bus.obi_req_i && !w_full;

    always_comb begin
        w_push_cmd       = '0;
        w_push_cmd.addr  = bus.obi_addr_i & WB_ADDR_MASK;
        w_push_cmd.we    = bus.obi_wr_en_i;
        w_push_cmd.be    = bus.obi_byte_en_i;
        w_push_cmd.wdata = bus.obi_wdata_i;
    end

    obi_wb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_din   (w_push_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_pop_cmd),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= WB_IDLE;
        else       r_state <= w_state_nxt;
    end

    // err beats ack, and ack beats a timeout landing on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_term      = 1'b0;
        w_rsp       = RSP_OK;
        case (r_state)
            WB_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WB_BUSY;
                end
            end
            WB_BUSY: begin
                if (bus.wb_err_i) begin
                    w_term = 1'b1;
                    w_rsp  = RSP_BUS_ERR;
                end else if (bus.wb_ack_i) begin
                    w_term = 1'b1;
                    w_rsp  = RSP_OK;
                end else if (w_timeout) begin
                    w_term = 1'b1;
                    w_rsp  = RSP_TIMEOUT;
                end
                if (w_term) w_state_nxt = WB_IDLE;
            end
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_wb_addr  <= '0;
            r_wb_wdata <= '0;
            r_wb_we    <= 1'b0;
            r_wb_be    <= '0;
            r_cyc      <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= w_term;
            r_err    <= w_term && (w_rsp != RSP_OK);
            r_rdata  <= (w_term && (w_rsp == RSP_OK) && !r_wb_we) ? bus.wb_rdata_i : '0;
            if (w_pop) begin
                r_wb_addr  <= w_pop_cmd.addr;
                r_wb_wdata <= w_pop_cmd.wdata;
                r_wb_we    <= w_pop_cmd.we;
                r_wb_be    <= w_pop_cmd.be;
                r_cyc      <= 1'b1;
                r_cnt      <= '0;
            end else if (w_term) begin
                r_cyc   <= 1'b0;
                r_wb_we <= 1'b0;
                r_wb_be <= '0;
            end else if ((r_state == WB_BUSY) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.wb_addr_o    = r_wb_addr;
    assign bus.wb_wdata_o   = r_wb_wdata;
    assign bus.wb_wr_en_o   = r_wb_we;
    assign bus.wb_byte_en_o = r_wb_be;
    assign bus.wb_cyc_o     = r_cyc;
    assign bus.wb_stb_o     = r_cyc;
    assign bus.obi_rvalid_o = r_rvalid;
    assign bus.obi_rdata_o  = r_rdata;
    assign bus.obi_err_o    = r_err;

endmodule
